// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : Shared types and constants for the load/store memory
//               controller: control FSM state encoding, BRAM read latency
//               and a helper for sizing arbiter priority pointers.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

    // Control FSM states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mcState_t;

    // Cycles from loadEn to valid loadData at the BRAM port
    localparam int BRAM_LATENCY = 1;

    // Pointer width for an arbiter of a given size; never below one bit so
    // single-port arbiters still have a legal register.
    function automatic int ptrWidth(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mc_arbiter
// Description : One-hot arbiter. The scan for a requester starts at the
//               priority pointer and wraps. With MC_ROUND_ROBIN_EN defined the
//               pointer moves to the port after each winner; otherwise the
//               pointer stays at port 0, giving fixed lowest-index priority.
// Ports       : clk   - clock
//               rst   - asynchronous reset, active low
//               req   - request vector (SIZE bits)
//               grant - one-hot grant vector (SIZE bits), combinational
// Config      : MC_ROUND_ROBIN_EN (optional macro)
// Revision    : 1.0 - initial release
// ============================================================================
module mc_arbiter
    import mc_pkg::*;
#(
    parameter int SIZE = 1
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] req,
    output logic [SIZE-1:0] grant
);

    localparam int PTR_W = ptrWidth(SIZE);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptrNext;
    logic             w_any;

    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        w_any = 1'b0;
`ifdef MC_ROUND_ROBIN_EN
        w_ptrNext = r_ptr;
`else
        w_ptrNext = '0;
`endif
        for (int i = 0; i < SIZE; i++) begin
            idx = (int'(r_ptr) + i) % SIZE;
            if (!w_any && req[idx]) begin
                w_any      = 1'b1;
                grant[idx] = 1'b1;
`ifdef MC_ROUND_ROBIN_EN
                w_ptrNext  = (idx == SIZE - 1) ? '0 : PTR_W'(idx + 1);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptrNext;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_controller_ldst.sv
`default_nettype none
// ============================================================================
// Module      : mem_controller_ldst
// Description : Load/store memory controller in front of a single-port-pair
//               BRAM. Stores are arbitrated and forwarded combinationally;
//               loads are arbitrated, issued combinationally and their
//               results parked in a one-entry slot per load port. A store
//               counter (credited by ctrl channels, debited per store) and a
//               slot-occupancy check decide when the run may end.
// Ports       : clk, rst                      - clock, async active-low reset
//               memStart_valid/_ready          - start handshake
//               memEnd_valid/_ready            - end handshake
//               ctrlEnd_valid/_ready           - "no more requests" handshake
//               ctrl, ctrl_valid, ctrl_ready   - store-count credits
//               ldAddr*, ldData*               - load request / result ports
//               stAddr*, stData*               - store request ports
//               loadData, loadEn, loadAddr     - BRAM read port
//               storeEn, storeAddr, storeData  - BRAM write port
// Config      : MC_ROUND_ROBIN_EN selects round-robin arbitration (default
//               fixed priority, lowest index wins)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_controller_ldst
    import mc_pkg::*;
#(
    parameter int NUM_CONTROLS = 1,
    parameter int NUM_LOADS    = 1,
    parameter int NUM_STORES   = 1,
    parameter int DATA_TYPE    = 32,
    parameter int ADDR_TYPE    = 32,
    parameter int CTRL_TYPE    = 32,
    parameter int COUNTER_TYPE = 32
)(
    input  logic                              clk,
    input  logic                              rst,

    input  logic                              memStart_valid,
    output logic                              memStart_ready,
    output logic                              memEnd_valid,
    input  logic                              memEnd_ready,
    input  logic                              ctrlEnd_valid,
    output logic                              ctrlEnd_ready,

    input  logic [NUM_CONTROLS*CTRL_TYPE-1:0] ctrl,
    input  logic [NUM_CONTROLS-1:0]           ctrl_valid,
    output logic [NUM_CONTROLS-1:0]           ctrl_ready,

    input  logic [NUM_LOADS*ADDR_TYPE-1:0]    ldAddr,
    input  logic [NUM_LOADS-1:0]              ldAddr_valid,
    output logic [NUM_LOADS-1:0]              ldAddr_ready,
    output logic [NUM_LOADS*DATA_TYPE-1:0]    ldData,
    output logic [NUM_LOADS-1:0]              ldData_valid,
    input  logic [NUM_LOADS-1:0]              ldData_ready,

    input  logic [NUM_STORES*ADDR_TYPE-1:0]   stAddr,
    input  logic [NUM_STORES*DATA_TYPE-1:0]   stData,
    input  logic [NUM_STORES-1:0]             stAddr_valid,
    input  logic [NUM_STORES-1:0]             stData_valid,
    output logic [NUM_STORES-1:0]             stAddr_ready,
    output logic [NUM_STORES-1:0]             stData_ready,

    input  logic [DATA_TYPE-1:0]              loadData,
    output logic                              loadEn,
    output logic [ADDR_TYPE-1:0]              loadAddr,
    output logic                              storeEn,
    output logic [ADDR_TYPE-1:0]              storeAddr,
    output logic [DATA_TYPE-1:0]              storeData
);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    mcState_t                r_state;
    mcState_t                w_stateNext;

    logic [COUNTER_TYPE-1:0] r_count;
    logic [COUNTER_TYPE-1:0] w_ctrlSum;
    logic [COUNTER_TYPE-1:0] w_countNext;

    logic [NUM_STORES-1:0]   w_stReq;
    logic [NUM_STORES-1:0]   w_stGrant;

    logic [NUM_LOADS-1:0]    w_ldReq;
    logic [NUM_LOADS-1:0]    w_ldGrant;
    logic [NUM_LOADS-1:0]    r_slotBusy;
    logic [NUM_LOADS-1:0]    r_slotValid;
    logic [NUM_LOADS-1:0]    w_busyNext;
    logic [NUM_LOADS-1:0]    w_consume;
    logic [NUM_LOADS-1:0]    w_capture;
    logic [NUM_LOADS-1:0]    r_rdPipe [BRAM_LATENCY];

    // ------------------------------------------------------------------
    // Store path: both halves of a port must be valid to compete. Requests
    // are masked while reset is held so the BRAM sees no writes.
    // ------------------------------------------------------------------
    assign w_stReq = stAddr_valid & stData_valid & {NUM_STORES{rst}};

    mc_arbiter #(
        .SIZE  (NUM_STORES)
    ) u_stArb (
        .clk   (clk),
        .rst   (rst),
        .req   (w_stReq),
        .grant (w_stGrant)
    );

    always_comb begin
        storeEn   = |w_stGrant;
        storeAddr = '0;
        storeData = '0;
        for (int s = 0; s < NUM_STORES; s++) begin
            if (w_stGrant[s]) begin
                storeAddr = stAddr[s*ADDR_TYPE +: ADDR_TYPE];
                storeData = stData[s*DATA_TYPE +: DATA_TYPE];
            end
        end
    end

    assign stAddr_ready = w_stGrant;
    assign stData_ready = w_stGrant;

    // ------------------------------------------------------------------
    // Load path: a port may issue only while its result slot is free, so
    // each port has at most one read in flight.
    // ------------------------------------------------------------------
    assign w_ldReq = ldAddr_valid & ~r_slotBusy & {NUM_LOADS{rst}};

    mc_arbiter #(
        .SIZE  (NUM_LOADS)
    ) u_ldArb (
        .clk   (clk),
        .rst   (rst),
        .req   (w_ldReq),
        .grant (w_ldGrant)
    );

    always_comb begin
        loadEn   = |w_ldGrant;
        loadAddr = '0;
        for (int l = 0; l < NUM_LOADS; l++) begin
            if (w_ldGrant[l]) begin
                loadAddr = ldAddr[l*ADDR_TYPE +: ADDR_TYPE];
            end
        end
    end

    assign ldAddr_ready = w_ldGrant;
    assign w_consume    = r_slotValid & ldData_ready;
    assign w_capture    = r_rdPipe[BRAM_LATENCY-1];
    // A grant and a consume can never hit the same port in one cycle:
    // granting needs a free slot, consuming needs an occupied one.
    assign w_busyNext   = (r_slotBusy | w_ldGrant) & ~w_consume;
    assign ldData_valid = r_slotValid;

    // Grant vector delayed by the BRAM latency marks which slot owns the
    // data currently on loadData.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < BRAM_LATENCY; k++) begin
                r_rdPipe[k] <= '0;
            end
            r_slotBusy  <= '0;
            r_slotValid <= '0;
        end else begin
            r_rdPipe[0] <= w_ldGrant;
            for (int k = 1; k < BRAM_LATENCY; k++) begin
                r_rdPipe[k] <= r_rdPipe[k-1];
            end
            r_slotBusy  <= w_busyNext;
            r_slotValid <= (r_slotValid | w_capture) & ~w_consume;
        end
    end

    generate
        for (genvar p = 0; p < NUM_LOADS; p++) begin : g_slot
            logic [DATA_TYPE-1:0] r_data;

            // Payload needs no reset; r_slotValid qualifies it.
            always_ff @(posedge clk) begin
                if (w_capture[p]) begin
                    r_data <= loadData;
                end
            end

            assign ldData[p*DATA_TYPE +: DATA_TYPE] = r_data;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Store counter: every credit and the store debit of a cycle are folded
    // into one modular update.
    // ------------------------------------------------------------------
    assign ctrl_ready = {NUM_CONTROLS{rst}};

    always_comb begin
        w_ctrlSum = '0;
        for (int c = 0; c < NUM_CONTROLS; c++) begin
            if (ctrl_valid[c]) begin
                w_ctrlSum = w_ctrlSum + COUNTER_TYPE'(ctrl[c*CTRL_TYPE +: CTRL_TYPE]);
            end
        end
        w_countNext = r_count + w_ctrlSum - COUNTER_TYPE'(storeEn);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_countNext;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // DRAIN looks at the post-update counter and slot occupancy so that the
    // final store or final consume of the run moves the FSM to DONE in the
    // very next cycle.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (memStart_valid) w_stateNext = RUN;
            RUN:     if (ctrlEnd_valid)  w_stateNext = DRAIN;
            DRAIN:   if ((w_countNext == '0) && (ctrl_valid == '0) &&
                         (w_busyNext == '0)) w_stateNext = DONE;
            DONE:    if (memEnd_ready)   w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_comb begin
        memStart_ready = 1'b0;
        ctrlEnd_ready  = 1'b0;
        memEnd_valid   = 1'b0;
        case (r_state)
            IDLE:    memStart_ready = 1'b1;
            RUN:     ctrlEnd_ready  = 1'b1;
            DONE:    memEnd_valid   = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_controller_ldst.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_controller_ldst
// Description : Self-checking bench for mem_controller_ldst with two control
//               channels, two load ports and two store ports, an 8-bit store
//               counter and 16-bit control words. A one-cycle BRAM model
//               answers reads. Expected store grants follow MC_ROUND_ROBIN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_controller_ldst;

    localparam int NC = 2;
    localparam int NL = 2;
    localparam int NS = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int CW = 16;
    localparam int KW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            memStart_valid, memStart_ready;
    logic            memEnd_valid, memEnd_ready;
    logic            ctrlEnd_valid, ctrlEnd_ready;
    logic [NC*CW-1:0] ctrl;
    logic [NC-1:0]   ctrl_valid, ctrl_ready;
    logic [NL*AW-1:0] ldAddr;
    logic [NL-1:0]   ldAddr_valid, ldAddr_ready;
    logic [NL*DW-1:0] ldData;
    logic [NL-1:0]   ldData_valid, ldData_ready;
    logic [NS*AW-1:0] stAddr;
    logic [NS*DW-1:0] stData;
    logic [NS-1:0]   stAddr_valid, stData_valid, stAddr_ready, stData_ready;
    logic [DW-1:0]   loadData = '0;
    logic            loadEn, storeEn;
    logic [AW-1:0]   loadAddr, storeAddr;
    logic [DW-1:0]   storeData;

    mem_controller_ldst #(
        .NUM_CONTROLS (NC), .NUM_LOADS (NL), .NUM_STORES (NS),
        .DATA_TYPE (DW), .ADDR_TYPE (AW), .CTRL_TYPE (CW), .COUNTER_TYPE (KW)
    ) dut (
        .clk (clk), .rst (rst),
        .memStart_valid (memStart_valid), .memStart_ready (memStart_ready),
        .memEnd_valid (memEnd_valid), .memEnd_ready (memEnd_ready),
        .ctrlEnd_valid (ctrlEnd_valid), .ctrlEnd_ready (ctrlEnd_ready),
        .ctrl (ctrl), .ctrl_valid (ctrl_valid), .ctrl_ready (ctrl_ready),
        .ldAddr (ldAddr), .ldAddr_valid (ldAddr_valid), .ldAddr_ready (ldAddr_ready),
        .ldData (ldData), .ldData_valid (ldData_valid), .ldData_ready (ldData_ready),
        .stAddr (stAddr), .stData (stData),
        .stAddr_valid (stAddr_valid), .stData_valid (stData_valid),
        .stAddr_ready (stAddr_ready), .stData_ready (stData_ready),
        .loadData (loadData), .loadEn (loadEn), .loadAddr (loadAddr),
        .storeEn (storeEn), .storeAddr (storeAddr), .storeData (storeData)
    );

    // One-cycle-latency BRAM read model
    logic [DW-1:0] mem [0:63];
    always @(posedge clk) begin
        if (loadEn) loadData <= mem[loadAddr[7:2]];
    end

    int nChecks = 0;
    int nErrors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  ctrlV;
        logic [15:0] c0, c1;
        logic [1:0]  sAV, sDV;
        logic        expEn;
        logic [1:0]  expRdy;
        logic [31:0] expAddr, expData;
        logic [7:0]  expCnt;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] cv, input logic [15:0] c0, input logic [15:0] c1,
                                input logic [1:0] av, input logic [1:0] dv, input logic en,
                                input logic [1:0] rdy, input logic [31:0] a, input logic [31:0] d,
                                input logic [7:0] cnt);
        vec_t v;
        v.ctrlV = cv; v.c0 = c0; v.c1 = c1; v.sAV = av; v.sDV = dv;
        v.expEn = en; v.expRdy = rdy; v.expAddr = a; v.expData = d; v.expCnt = cnt;
        return v;
    endfunction

    vec_t vecs [11];

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // Store port 0 sits at 0x100/0xD0, port 1 at 0x200/0xD1
        vecs[0]  = mk(2'b01, 16'd3,     16'd0, 2'b00, 2'b00, 1'b0, 2'b00, 32'h0,   32'h0,  8'd3);
        vecs[1]  = mk(2'b01, 16'd5,     16'd0, 2'b01, 2'b01, 1'b1, 2'b01, 32'h100, 32'hD0, 8'd7);
        vecs[2]  = mk(2'b11, 16'h0105,  16'd2, 2'b00, 2'b00, 1'b0, 2'b00, 32'h0,   32'h0,  8'd14);
`ifdef MC_ROUND_ROBIN_EN
        vecs[3]  = mk(2'b00, 16'd0,     16'd0, 2'b11, 2'b11, 1'b1, 2'b10, 32'h200, 32'hD1, 8'd13);
`else
        vecs[3]  = mk(2'b00, 16'd0,     16'd0, 2'b11, 2'b11, 1'b1, 2'b01, 32'h100, 32'hD0, 8'd13);
`endif
        vecs[4]  = mk(2'b00, 16'd0,     16'd0, 2'b11, 2'b10, 1'b1, 2'b10, 32'h200, 32'hD1, 8'd12);
        vecs[5]  = mk(2'b00, 16'd0,     16'd0, 2'b01, 2'b00, 1'b0, 2'b00, 32'h0,   32'h0,  8'd12);
        vecs[6]  = mk(2'b01, 16'd0,     16'd0, 2'b00, 2'b00, 1'b0, 2'b00, 32'h0,   32'h0,  8'd12);
        vecs[7]  = mk(2'b01, 16'h00F4,  16'd0, 2'b00, 2'b00, 1'b0, 2'b00, 32'h0,   32'h0,  8'd0);
        vecs[8]  = mk(2'b00, 16'd0,     16'd0, 2'b11, 2'b01, 1'b1, 2'b01, 32'h100, 32'hD0, 8'hFF);
        vecs[9]  = mk(2'b01, 16'd1,     16'd0, 2'b01, 2'b01, 1'b1, 2'b01, 32'h100, 32'hD0, 8'hFF);
        vecs[10] = mk(2'b11, 16'hFF01,  16'd0, 2'b00, 2'b00, 1'b0, 2'b00, 32'h0,   32'h0,  8'h00);

        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[8] = 32'hAA;   // 0x20
        mem[9] = 32'hBB;   // 0x24

        // Reset with traffic pending on every input
        rst = 1'b0;
        memStart_valid = 1'b0; memEnd_ready = 1'b0; ctrlEnd_valid = 1'b1;
        ctrl = {16'd7, 16'd7}; ctrl_valid = 2'b11;
        ldAddr = {32'h24, 32'h20}; ldAddr_valid = 2'b11; ldData_ready = 2'b11;
        stAddr = {32'h200, 32'h100}; stData = {32'hD1, 32'hD0};
        stAddr_valid = 2'b11; stData_valid = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        check("rst memStart_ready", memStart_ready, 1);
        check("rst memEnd_valid", memEnd_valid, 0);
        check("rst ctrlEnd_ready", ctrlEnd_ready, 0);
        check("rst storeEn", storeEn, 0);
        check("rst loadEn", loadEn, 0);
        check("rst stAddr_ready", stAddr_ready, 0);
        check("rst ldAddr_ready", ldAddr_ready, 0);
        check("rst ldData_valid", ldData_valid, 0);
        check("rst count", dut.r_count, 0);

        @(negedge clk);
        ctrlEnd_valid = 1'b0; ctrl_valid = 2'b00; ldAddr_valid = 2'b00;
        stAddr_valid = 2'b00; stData_valid = 2'b00;
        rst = 1'b1;

        // Table: counter arithmetic and store arbitration
        for (int v = 0; v < 11; v++) begin
            @(negedge clk);
            ctrl_valid = vecs[v].ctrlV;
            ctrl = {vecs[v].c1, vecs[v].c0};
            stAddr_valid = vecs[v].sAV;
            stData_valid = vecs[v].sDV;
            #1;
            check($sformatf("v%0d storeEn", v), storeEn, vecs[v].expEn);
            check($sformatf("v%0d stAddr_ready", v), stAddr_ready, vecs[v].expRdy);
            check($sformatf("v%0d stData_ready", v), stData_ready, vecs[v].expRdy);
            check($sformatf("v%0d ctrl_ready", v), ctrl_ready, 2'b11);
            if (vecs[v].expEn) begin
                check($sformatf("v%0d storeAddr", v), storeAddr, vecs[v].expAddr);
                check($sformatf("v%0d storeData", v), storeData, vecs[v].expData);
            end
            @(posedge clk); #1;
            check($sformatf("v%0d count", v), dut.r_count, vecs[v].expCnt);
        end
        @(negedge clk);
        ctrl_valid = 2'b00; stAddr_valid = 2'b00; stData_valid = 2'b00;

        // Run: ctrl=3, ctrlEnd, three stores, end in the cycle after the last
        memStart_valid = 1'b1;
        @(posedge clk); #1;
        check("A ctrlEnd_ready in RUN", ctrlEnd_ready, 1);
        @(negedge clk);
        memStart_valid = 1'b0; ctrl_valid = 2'b01; ctrl = {16'd0, 16'd3};
        @(posedge clk); #1;
        check("A count after credit", dut.r_count, 3);
        @(negedge clk);
        ctrl_valid = 2'b00; ctrlEnd_valid = 1'b1;
        @(posedge clk); #1;
        check("A ctrlEnd_ready in DRAIN", ctrlEnd_ready, 0);
        check("A memEnd_valid in DRAIN", memEnd_valid, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ctrlEnd_valid = 1'b0;
            stAddr[31:0] = 32'h10 + 32'(4 * k);
            stAddr_valid = 2'b01; stData_valid = 2'b01;
            #1;
            check($sformatf("A store%0d storeEn", k), storeEn, 1);
            check($sformatf("A store%0d storeAddr", k), storeAddr, 32'h10 + 32'(4 * k));
            @(posedge clk); #1;
            check($sformatf("A store%0d count", k), dut.r_count, 2 - k);
            check($sformatf("A store%0d memEnd_valid", k), memEnd_valid, (k == 2) ? 1 : 0);
        end
        @(negedge clk);
        stAddr_valid = 2'b00; stData_valid = 2'b00; memEnd_ready = 1'b1;
        @(posedge clk); #1;
        check("A back to IDLE", memStart_ready, 1);
        check("A memEnd_valid dropped", memEnd_valid, 0);
        @(negedge clk);
        memEnd_ready = 1'b0; stAddr[31:0] = 32'h100;

        // Two loads at once, port 0 result held back to block DRAIN
        memStart_valid = 1'b1;
        @(negedge clk);
        memStart_valid = 1'b0;
        ldAddr = {32'h24, 32'h20}; ldAddr_valid = 2'b11; ldData_ready = 2'b10;
        ctrlEnd_valid = 1'b1;
        #1;
        check("B N loadEn", loadEn, 1);
        check("B N loadAddr", loadAddr, 32'h20);
        check("B N ldAddr_ready", ldAddr_ready, 2'b01);
        @(negedge clk);
        ctrlEnd_valid = 1'b0;
        #1;
        check("B N+1 loadAddr", loadAddr, 32'h24);
        check("B N+1 ldAddr_ready", ldAddr_ready, 2'b10);
        check("B N+1 ldData_valid", ldData_valid, 2'b00);
        @(posedge clk); #1;
        check("B N+2 ldData_valid", ldData_valid, 2'b01);
        check("B N+2 ldData0", ldData[31:0], 32'hAA);
        @(negedge clk);
        ldAddr_valid = 2'b01;
        #1;
        check("B no regrant port0", loadEn, 0);
        @(posedge clk); #1;
        check("B N+3 ldData_valid", ldData_valid, 2'b11);
        check("B N+3 ldData1", ldData[63:32], 32'hBB);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check($sformatf("B hold%0d loadEn", k), loadEn, 0);
            @(posedge clk); #1;
            check($sformatf("B hold%0d ldData_valid", k), ldData_valid, 2'b01);
            check($sformatf("B hold%0d memEnd_valid", k), memEnd_valid, 0);
        end
        @(negedge clk);
        ldData_ready = 2'b11; ldAddr_valid = 2'b00;
        #1;
        check("B consume memEnd_valid", memEnd_valid, 0);
        @(posedge clk); #1;
        check("B after consume memEnd_valid", memEnd_valid, 1);
        check("B after consume ldData_valid", ldData_valid, 2'b00);
        @(negedge clk);
        memEnd_ready = 1'b1; ldData_ready = 2'b00;
        @(negedge clk);
        memEnd_ready = 1'b0;

        // Both store ports permanently eligible
        stAddr_valid = 2'b11; stData_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] expG;
`ifdef MC_ROUND_ROBIN_EN
            expG = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
            expG = 2'b01;
`endif
            #1;
            check($sformatf("C grant%0d", k), stAddr_ready, expG);
            @(negedge clk);
        end
        stAddr_valid = 2'b00; stData_valid = 2'b00;

        // Reset in DRAIN with a load outstanding
        memStart_valid = 1'b1;
        @(negedge clk);
        memStart_valid = 1'b0; ctrlEnd_valid = 1'b1;
        ldAddr[31:0] = 32'h20; ldAddr_valid = 2'b01; ldData_ready = 2'b00;
        #1;
        check("D loadEn", loadEn, 1);
        @(negedge clk);
        ctrlEnd_valid = 1'b0; ldAddr_valid = 2'b00;
        #1;
        check("D in DRAIN memStart_ready", memStart_ready, 0);
        #1 rst = 1'b0;
        #1;
        check("D rst memStart_ready", memStart_ready, 1);
        check("D rst ldData_valid", ldData_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("D post%0d ldData_valid", k), ldData_valid, 0);
            check($sformatf("D post%0d memStart_ready", k), memStart_ready, 1);
        end

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_controller_ldst.md
MEM_CONTROLLER_LDST -- requirements
Module: mem_controller_ldst

Interface
REQ-001 SHALL have parameter NUM_CONTROLS, default 1, number of store-count control channels.
REQ-002 SHALL have parameter NUM_LOADS, default 1, number of load access ports.
REQ-003 SHALL have parameter NUM_STORES, default 1, number of store access ports.
REQ-004 SHALL have parameters DATA_TYPE, default 32, and ADDR_TYPE, default 32, giving data and address widths.
REQ-005 SHALL have parameters CTRL_TYPE, default 32, giving the per-channel control width, and COUNTER_TYPE, default 32, giving the store counter width.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (the clock); rst input 1 (asynchronous reset, active-low).
REQ-007 SHALL have memStart_valid input 1, memStart_ready output 1 (start handshake); memEnd_valid output 1, memEnd_ready input 1 (end handshake); ctrlEnd_valid input 1, ctrlEnd_ready output 1 ("no more requests" handshake).
REQ-008 SHALL have ctrl input NUM_CONTROLS*CTRL_TYPE, ctrl_valid input NUM_CONTROLS, ctrl_ready output NUM_CONTROLS (store counts).
REQ-009 SHALL have ldAddr input NUM_LOADS*ADDR_TYPE, ldAddr_valid input NUM_LOADS, ldAddr_ready output NUM_LOADS; ldData output NUM_LOADS*DATA_TYPE, ldData_valid output NUM_LOADS, ldData_ready input NUM_LOADS.
REQ-010 SHALL have stAddr input NUM_STORES*ADDR_TYPE, stData input NUM_STORES*DATA_TYPE, stAddr_valid/stData_valid inputs NUM_STORES, stAddr_ready/stData_ready outputs NUM_STORES.
REQ-011 SHALL have the BRAM port: loadData input DATA_TYPE, loadEn output 1, loadAddr output ADDR_TYPE, storeEn output 1, storeAddr output ADDR_TYPE, storeData output DATA_TYPE.

Function
REQ-012 SHALL keep ctrl_ready at all ones; each ctrl channel with ctrl_valid high in a cycle adds its value, zero-extended or truncated to COUNTER_TYPE, to the counter.
REQ-013 SHALL decrement the counter by 1 in every cycle in which storeEn is high; all additions and the decrement in one cycle SHALL be applied as a single net update, modulo 2^COUNTER_TYPE.
REQ-014 SHALL treat a store port as eligible only when stAddr_valid and stData_valid are both high; at most one store SHALL be granted per cycle.
REQ-015 SHALL drive the granted store onto storeEn, storeAddr and storeData in the same cycle, combinationally, and SHALL assert stAddr_ready and stData_ready of that port only.
REQ-016 SHALL treat a load port as eligible when ldAddr_valid is high and its one-entry result slot is empty; at most one load SHALL be granted per cycle, with loadEn, loadAddr and ldAddr_ready driven combinationally.
REQ-017 SHALL assume a BRAM read latency of 1: loadData from a grant in cycle N SHALL be captured into that port's slot at the end of cycle N+1, with ldData_valid high from cycle N+2 until ldData_valid and ldData_ready are both high.
REQ-018 SHALL mark a slot busy from the grant cycle, so that a port has at most one load outstanding; a slot SHALL become free in the cycle after its result is consumed.
REQ-019 SHALL run a control FSM with states IDLE, RUN, DRAIN and DONE.
REQ-020 IDLE: memStart_ready=1; on a memStart handshake the FSM SHALL go to RUN.
REQ-021 RUN: ctrlEnd_ready=1; on a ctrlEnd handshake the FSM SHALL go to DRAIN.
REQ-022 DRAIN: the FSM SHALL go to DONE when the counter is 0, no ctrl_valid bit is high and no load slot is busy.
REQ-023 DONE: memEnd_valid=1; on a memEnd handshake the FSM SHALL go to IDLE.
REQ-024 SHALL accept memory traffic in every state; the FSM gates only the end condition.

Reset
REQ-025 While rst is low, the FSM SHALL be in IDLE, the counter 0, all slots empty and arbiter priority pointers at port 0.
REQ-026 During reset, memStart_ready SHALL be 1 and all other handshake outputs 0; loadEn and storeEn SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL discard all outstanding loads with no result delivered.

Configuration
REQ-028 With macro MC_ROUND_ROBIN_EN defined, both arbiters SHALL be round-robin, with the priority pointer moving to the port after the winner on each grant.
REQ-029 Without MC_ROUND_ROBIN_EN, both arbiters SHALL be fixed-priority, with the lowest index winning.

Structure
REQ-030 Package mc_pkg SHALL hold the FSM state enum (IDLE, RUN, DRAIN, DONE) and the BRAM latency constant (1).
REQ-031 Sub-module mc_arbiter (parameter SIZE, request in, one-hot grant out) SHALL be instantiated once for loads and once for stores.

Verification
REQ-032 ctrl=3; stores to addresses 0x10, 0x14, 0x18; then ctrlEnd -> three storeEn pulses, counter 3->0, memEnd_valid in the cycle after the third store.
REQ-033 ctrl=5 and a store in the same cycle -> counter reads 4 next cycle.
REQ-034 Two load ports request 0x20 and 0x24 at once, with BRAM contents 0xAA and 0xBB, MC_ROUND_ROBIN_EN defined -> port 0 granted in cycle N and port 1 in N+1; ldData 0xAA valid at N+2 and 0xBB at N+3.
REQ-035 ldData_ready held low on port 0 -> slot stays busy, no second grant to port 0, DRAIN does not exit until the result is consumed.
REQ-036 Without MC_ROUND_ROBIN_EN, both store ports permanently eligible -> port 0 granted every cycle.
REQ-037 rst pulsed low in DRAIN with one load outstanding -> IDLE, memStart_ready=1, no ldData_valid afterwards.
